// File: rtl/cfg_sp_mem_loader.sv
// rtl/cfg_sp_mem_loader.sv - run-time image loader for a single-port memory
//
// Takes a command (start address, entry count) and a stream of SEGW-bit
// segments. It packs SEGS segments per entry, first segment least
// significant, and issues one single-port write per entry. The address
// increments after each write and wraps from DEPTH-1 back to 0.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_addr, cmd_len     first entry address; number of entries (0..DEPTH)
//   s_valid/s_ready       segment handshake
//   s_data                segment payload
//   me, we, addr, wdata   single-port memory write interface
//   busy                  high whenever the loader is not idle
//   done, err             one-cycle completion pulse; err marks a rejected command
module cfg_sp_mem_loader #(
  parameter  int BLKS      = 2,
  parameter  int BDEPTH    = 32,
  parameter  int SEGS      = 2,
  parameter  int SEGW      = 32,
  localparam int DEPTH     = BLKS * BDEPTH,
  localparam int ADDR_BITS = ($clog2(DEPTH) >= 1) ? $clog2(DEPTH) : 1,
  localparam int LEN_BITS  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [LEN_BITS-1:0]    cmd_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SEGW-1:0]        s_data,
  output logic                   me,
  output logic                   we,
  output logic [ADDR_BITS-1:0]   addr,
  output logic [SEGS*SEGW-1:0]   wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_BITS = (SEGS > 1) ? $clog2(SEGS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    seg_cnt_q, seg_cnt_d;
  logic [ADDR_BITS-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_BITS-1:0]    rem_q, rem_d;
  logic [SEGS*SEGW-1:0]   asm_q, asm_d;
  logic                   err_flag_q, err_flag_d;

  logic                   cmd_ready_q, cmd_ready_d;
  logic                   s_ready_q, s_ready_d;
  logic                   me_q, me_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [SEGS*SEGW-1:0]   wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   addr_bad;
  logic                   len_bad;

  // When DEPTH fills the whole address space no out-of-range address can be
  // expressed, so the check collapses to a constant.
  if (DEPTH < (1 << ADDR_BITS)) begin : g_addr_chk
    assign addr_bad = (cmd_addr >= ADDR_BITS'(DEPTH));
  end else begin : g_addr_full
    assign addr_bad = 1'b0;
  end

  assign len_bad = (cmd_len > LEN_BITS'(DEPTH));

  always_comb begin
    state_d    = state_q;
    seg_cnt_d  = seg_cnt_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    asm_d      = asm_q;
    err_flag_d = err_flag_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cur_addr_d = cmd_addr;
          rem_d      = cmd_len;
          seg_cnt_d  = '0;
          err_flag_d = addr_bad || len_bad;
          if (addr_bad || len_bad || (cmd_len == '0)) begin
            state_d = FIN;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (s_valid) begin
          asm_d[int'(seg_cnt_q)*SEGW +: SEGW] = s_data;
          if (seg_cnt_q == CNT_BITS'(SEGS - 1)) begin
            seg_cnt_d = '0;
            state_d   = WRITE;
          end else begin
            seg_cnt_d = seg_cnt_q + CNT_BITS'(1);
          end
        end
      end
      WRITE: begin
        // Explicit wrap compare: DEPTH need not be a power of two.
        cur_addr_d = (cur_addr_q == ADDR_BITS'(DEPTH - 1)) ? '0
                                                          : cur_addr_q + ADDR_BITS'(1);
        rem_d      = rem_q - LEN_BITS'(1);
        seg_cnt_d  = '0;
        state_d    = (rem_q == LEN_BITS'(1)) ? FIN : FILL;
      end
      FIN: begin
        err_flag_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so each flop is valid during
    // the state cycle it belongs to. WRITE is only ever entered from FILL,
    // where cur_addr is unchanged, so cur_addr_q is the write address.
    cmd_ready_d = (state_d == IDLE);
    s_ready_d   = (state_d == FILL);
    busy_d      = (state_d != IDLE);
    me_d        = (state_d == WRITE);
    addr_d      = me_d ? cur_addr_q : addr_q;
    wdata_d     = me_d ? asm_d : wdata_q;
    done_d      = (state_d == FIN);
    err_d       = (state_d == FIN) && err_flag_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_cnt_q   <= '0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      asm_q       <= '0;
      err_flag_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      me_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      asm_q       <= asm_d;
      err_flag_q  <= err_flag_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      me_q        <= me_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign s_ready   = s_ready_q;
  assign me        = me_q;
  assign we        = me_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
